pipeline_wb_arbiter: RTL
========================

PIPELINE_WB_ARBITER -- requirements
Module: pipeline_wb_arbiter

Interface
REQ-001 The block SHALL take parameter DEPTH, default 4, giving the number of long-latency result FIFO entries (power of 2, minimum 2).
REQ-002 The block SHALL take parameter STARVE_MAX, default 8, giving the number of consecutive blocked-pop cycles before the ALU path is held off.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port alu_valid, input, 1: ALU writeback result present this cycle; it has no backpressure.
REQ-006 Port alu_rd, input, 5: ALU destination register.
REQ-007 Port alu_data, input, 32: ALU result.
REQ-008 Port lsu_valid, input, 1: long-latency (load/mul) result offered.
REQ-009 Port lsu_ready, output, 1: result accepted when lsu_valid && lsu_ready.
REQ-010 Port lsu_rd, input, 5: long-latency destination register.
REQ-011 Port lsu_data, input, 32: long-latency result.
REQ-012 Port rd_we, output, 1: register file write enable.
REQ-013 Port rd_addr, output, 5: register file write address.
REQ-014 Port rd_data, output, 32: register file write data.
REQ-015 Port alu_hold, output, 1: request to upstream to present no ALU result this cycle.
REQ-016 Port fifo_count, output, $clog2(DEPTH)+1: current FIFO occupancy.
REQ-017 Port proto_err, output, 1: sticky flag set when alu_valid is seen while alu_hold=1.

Function
REQ-018 rd_we, rd_addr and rd_data SHALL be registered; every write SHALL appear exactly 1 cycle after its selection.
REQ-019 Selection priority per cycle SHALL be: (1) alu_valid; (2) FIFO head when FIFO is non-empty; (3) bypass of an accepted LSU result when the FIFO is empty and alu_valid=0.
REQ-020 An ALU result with alu_rd=0 SHALL win selection but drive rd_we=0 in the following cycle.
REQ-021 An accepted LSU result with lsu_rd=0 SHALL be discarded: it is neither enqueued nor written.
REQ-022 An accepted LSU result not selected for bypass SHALL be enqueued at the FIFO tail.
REQ-023 LSU results SHALL be written in strict acceptance order.
REQ-024 lsu_ready SHALL be combinational: 1 iff fifo_count < DEPTH.
REQ-025 Push and pop in the same cycle SHALL leave fifo_count unchanged, with read and write pointers wrapping modulo DEPTH.
REQ-026 The starve counter SHALL increment on each cycle where the FIFO is non-empty and alu_valid blocks the pop.
REQ-027 The starve counter SHALL clear on any pop or when the FIFO is empty.
REQ-028 When the starve counter reaches STARVE_MAX, alu_hold SHALL assert (registered) for exactly 1 cycle, and the counter SHALL then clear.
REQ-029 If alu_valid=1 while alu_hold=1, the ALU SHALL still win selection and proto_err SHALL set; proto_err clears only on reset.
REQ-030 In any cycle with no selection, rd_we SHALL be 0, and rd_addr and rd_data SHALL hold their previous values.

Reset
REQ-031 reset=1 at a clock edge SHALL clear rd_we, rd_addr, rd_data, alu_hold, proto_err, the starve counter, fifo_count and both pointers to 0.
REQ-032 Reset SHALL discard all FIFO contents, including when asserted mid-operation.
REQ-033 While reset=1, lsu_ready SHALL be 0 and no input SHALL be accepted.
REQ-034 All outputs SHALL be defined in the first cycle after reset deasserts, with lsu_ready=1.

Verification
REQ-035 ALU only: alu_valid=1, rd=5, data=0xDEADBEEF at cycle N -> rd_we=1, rd_addr=5, rd_data=0xDEADBEEF at N+1.
REQ-036 Bypass: FIFO empty, alu_valid=0, lsu rd=7, data=0x11 -> write to x7 at N+1, fifo_count stays 0.
REQ-037 Contention: ALU x1 and LSU x2 in the same cycle, then idle -> x1 written at N+1, x2 at N+2, fifo_count 1 then 0.
REQ-038 Full/backpressure: alu_valid held 1 with 5 LSU offers -> 4 accepted, lsu_ready=0 at count=4, drained in acceptance order once ALU idles.
REQ-039 Starvation: FIFO non-empty with alu_valid=1 for 8 cycles -> alu_hold=1 for 1 cycle, FIFO head written; driving alu_valid in the hold cycle -> proto_err=1.
REQ-040 Reset and x0: reset with 3 entries queued -> count=0, no writes after reset; ALU or LSU targeting rd=0 -> rd_we never asserted.

Source files
------------

// File: rtl/pipeline_wb_arbiter.sv
// Writeback arbiter: merges a no-backpressure ALU result stream with a
// long-latency (load/mul) stream into a single register-file write port.
// Long-latency results queue in a small FIFO while the ALU owns the port.
// A starvation counter asks upstream to skip one ALU slot if the FIFO
// head has been blocked for too long.
module pipeline_wb_arbiter #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_rd,
    input  logic [31:0]              alu_data,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [4:0]               lsu_rd,
    input  logic [31:0]              lsu_data,
    output logic                     rd_we,
    output logic [4:0]               rd_addr,
    output logic [31:0]              rd_data,
    output logic                     alu_hold,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     proto_err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

    // FIFO storage; contents need no reset because the pointers define validity
    wb_entry_t         mem [DEPTH];

    // registered state
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [SW-1:0]     starve_q;
    logic              rd_we_q;
    logic [4:0]        rd_addr_q;
    logic [31:0]       rd_data_q;
    logic              hold_q;
    logic              err_q;

    // next-state values
    logic [PW-1:0]     wr_ptr_d, rd_ptr_d;
    logic [CW-1:0]     count_d;
    logic [SW-1:0]     starve_d;
    logic              rd_we_d;
    logic [4:0]        rd_addr_d;
    logic [31:0]       rd_data_d;
    logic              hold_d;
    logic              err_d;

    // per-cycle decisions
    logic              fifo_empty;
    logic              fifo_full;
    logic              lsu_accept;
    logic              lsu_keep;
    logic              push;
    logic              pop;
    logic              bypass;
    wb_entry_t         head;
    wb_entry_t         tail_entry;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(DEPTH));
    assign head       = mem[rd_ptr_q];
    assign tail_entry = '{rd: lsu_rd, data: lsu_data};

    // Acceptance is combinational so the LSU sees space in the same cycle
    assign lsu_ready  = !reset && !fifo_full;
    assign lsu_accept = lsu_valid && lsu_ready;
    // Results for x0 are dropped at the door; they never occupy a slot
    assign lsu_keep   = lsu_accept && (lsu_rd != 5'd0);

    assign rd_we      = rd_we_q;
    assign rd_addr    = rd_addr_q;
    assign rd_data    = rd_data_q;
    assign alu_hold   = hold_q;
    assign proto_err  = err_q;
    assign fifo_count = count_q;

    // Selection, FIFO bookkeeping and starvation tracking
    always_comb begin
        pop       = 1'b0;
        bypass    = 1'b0;
        push      = 1'b0;
        rd_we_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        starve_d  = starve_q;
        hold_d    = 1'b0;
        err_d     = err_q;

        // ALU always wins; an x0 destination consumes the slot without writing
        if (alu_valid) begin
            if (alu_rd != 5'd0) begin
                rd_we_d   = 1'b1;
                rd_addr_d = alu_rd;
                rd_data_d = alu_data;
            end
        end else if (!fifo_empty) begin
            pop       = 1'b1;
            rd_we_d   = 1'b1;
            rd_addr_d = head.rd;
            rd_data_d = head.data;
        end else if (lsu_keep) begin
            bypass    = 1'b1;
            rd_we_d   = 1'b1;
            rd_addr_d = lsu_rd;
            rd_data_d = lsu_data;
        end

        push = lsu_keep && !bypass;

        if (push) begin
            wr_ptr_d = PW'(wr_ptr_q + PW'(1));
        end
        if (pop) begin
            rd_ptr_d = PW'(rd_ptr_q + PW'(1));
        end

        case ({push, pop})
            2'b10:   count_d = CW'(count_q + CW'(1));
            2'b01:   count_d = CW'(count_q - CW'(1));
            default: count_d = count_q;
        endcase

        // Non-empty and not popping can only mean the ALU blocked the head
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (SW'(starve_q + SW'(1)) == SW'(STARVE_MAX)) begin
            starve_d = '0;
            hold_d   = 1'b1;
        end else begin
            starve_d = SW'(starve_q + SW'(1));
        end

        if (alu_valid && hold_q) begin
            err_d = 1'b1;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            rd_we_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            hold_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            starve_q  <= starve_d;
            rd_we_q   <= rd_we_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            hold_q    <= hold_d;
            err_q     <= err_d;
        end
    end

    // FIFO tail write; push is already gated off while reset is high
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= tail_entry;
        end
    end

endmodule
